inst_queue_multi: RTL and testbench

- Parametrised successor to the fetch-side instruction buffer. Sits between IFU and decode.
- Accepts up to IN_W instruction bundles per cycle and compacts sparse valid lanes into a circular queue.
- Presents up to OUT_W bundles per cycle to the backend under branch/delay-slot grouping rules.
- Adds occupancy reporting and an optional hold mode that keeps a control-transfer instruction and its delay slot in the same group.

---
 rtl/inst_queue_multi.sv | 110 +++++++++++
 tb/tb_inst_queue_multi.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue_multi.sv
// Multi-lane instruction queue between fetch and decode.
// Compacts sparse input lanes into a ring, issues branch-aware groups.
module inst_queue_multi #(
    parameter int DATA_W  = 64,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 2,
    parameter int DEPTH   = 16,
    parameter int HOLD_DS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [IN_W-1:0]           in_valid,
    input  logic [IN_W*DATA_W-1:0]    in_data,
    input  logic [IN_W-1:0]           in_is_ctrl,
    output logic                      in_ready,
    output logic [OUT_W-1:0]          out_valid,
    output logic [OUT_W*DATA_W-1:0]   out_data,
    output logic [OUT_W-1:0]          out_is_ctrl,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      pause_req
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     headPtr;
    logic [PW-1:0]     tailPtr;
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [DEPTH-1:0]  ctrlMem;

    logic [PW-1:0]     freeCnt;
    logic [PW-1:0]     pushCnt;
    logic [PW-1:0]     popCnt;
    logic [AW-1:0]     wrIdx [IN_W];
    logic              doPush;
    logic              doPop;

    assign count     = tailPtr - headPtr;
    assign freeCnt   = PW'(DEPTH) - count;
    assign in_ready  = freeCnt >= PW'(IN_W);
    assign pause_req = !in_ready;
    assign doPush    = in_ready && !flush && !rst;
    assign doPop     = out_ready && out_valid[0];

    // Slot of each valid input lane, skipping gaps between valid lanes
    always_comb begin
        pushCnt = '0;
        for (int i = 0; i < IN_W; i++) begin
            wrIdx[i] = tailPtr[AW-1:0] + pushCnt[AW-1:0];
            pushCnt  = pushCnt + PW'(in_valid[i]);
        end
    end

    // Issue group: thermometer valid, control only in lane 0, group
    // closes after the delay slot of a leading control instruction
    always_comb begin
        logic          headCtrl;
        logic          chain;
        logic [AW-1:0] idx;
        out_valid   = '0;
        out_data    = '0;
        out_is_ctrl = '0;
        popCnt      = '0;
        headCtrl    = ctrlMem[headPtr[AW-1:0]];
        chain       = 1'b0;
        for (int k = 0; k < OUT_W; k++) begin
            idx = headPtr[AW-1:0] + AW'(k);
            out_data[k*DATA_W +: DATA_W] = dataMem[idx];
            out_is_ctrl[k] = ctrlMem[idx];
            if (k == 0) begin
                chain = (count != '0)
                     && !((HOLD_DS != 0) && headCtrl
                          && (count < PW'(2)));
            end else begin
                chain = chain
                     && (count > PW'(k))
                     && !ctrlMem[idx]
                     && !((k >= 2) && headCtrl);
            end
            out_valid[k] = chain;
            popCnt = popCnt + PW'(chain);
        end
    end

    // Head/tail pointers; rst and flush void any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            headPtr <= '0;
            tailPtr <= '0;
        end else begin
            if (doPush) tailPtr <= tailPtr + pushCnt;
            if (doPop)  headPtr <= headPtr + popCnt;
        end
    end

    // Storage writes for accepted lanes; contents need no reset
    always_ff @(posedge clk) begin
        if (doPush) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in_valid[i]) begin
                    dataMem[wrIdx[i]] <= in_data[i*DATA_W +: DATA_W];
                    ctrlMem[wrIdx[i]] <= in_is_ctrl[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_queue_multi.sv
// Scoreboard bench for inst_queue_multi: directed test-plan
// sequences followed by randomized traffic against a FIFO model.
module tb_inst_queue_multi;

    localparam int DATA_W = 64;
    localparam int IN_W   = 2;
    localparam int OUT_W  = 2;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              c;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [IN_W-1:0] inValid = '0;
    logic [IN_W*DATA_W-1:0] inData = '0;
    logic [IN_W-1:0] inCtrl = '0;
    logic outReady = 1'b0;

    logic inReady;
    logic [OUT_W-1:0] outValid;
    logic [OUT_W*DATA_W-1:0] outData;
    logic [OUT_W-1:0] outCtrl;
    logic [CW-1:0] count;
    logic pauseReq;

    logic outReadyB = 1'b0;
    logic inReadyB;
    logic [OUT_W-1:0] outValidB;
    logic [OUT_W*DATA_W-1:0] outDataB;
    logic [OUT_W-1:0] outCtrlB;
    logic [CW-1:0] countB;
    logic pauseReqB;

    int checks = 0;
    int failures = 0;
    bit monOn = 1'b0;
    ent_t q[$];

    inst_queue_multi #(
        .DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W),
        .DEPTH(DEPTH), .HOLD_DS(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_data(inData),
        .in_is_ctrl(inCtrl), .in_ready(inReady),
        .out_valid(outValid), .out_data(outData),
        .out_is_ctrl(outCtrl), .out_ready(outReady),
        .count(count), .pause_req(pauseReq)
    );

    inst_queue_multi #(
        .DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W),
        .DEPTH(DEPTH), .HOLD_DS(0)
    ) dutNoHold (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_data(inData),
        .in_is_ctrl(inCtrl), .in_ready(inReadyB),
        .out_valid(outValidB), .out_data(outDataB),
        .out_is_ctrl(outCtrlB), .out_ready(outReadyB),
        .count(countB), .pause_req(pauseReqB)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act,
                       logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Group size from the issue rules, applied to the model FIFO
    function automatic int grpSize();
        int n;
        int g;
        bit hc;
        n = q.size();
        if (n == 0) return 0;
        hc = q[0].c;
        if (hc && n < 2) return 0;
        g = 1;
        for (int k = 1; k < OUT_W; k++) begin
            if (k >= n) break;
            if (q[k].c) break;
            if (k >= 2 && hc) break;
            g++;
        end
        return g;
    endfunction

    // Reference model: pops the issued group, then appends accepted lanes
    always @(posedge clk) begin
        int g;
        bit acc;
        if (rst || flush) begin
            q.delete();
        end else begin
            g = grpSize();
            acc = (DEPTH - q.size()) >= IN_W;
            if (outReady && g > 0)
                for (int i = 0; i < g; i++) void'(q.pop_front());
            if (acc)
                for (int i = 0; i < IN_W; i++)
                    if (inValid[i])
                        q.push_back({inData[i*DATA_W +: DATA_W],
                                     inCtrl[i]});
        end
    end

    // Monitor: compare presented group and status against the model
    always @(negedge clk) begin
        int g;
        logic [OUT_W-1:0] expV;
        bit expRdy;
        if (monOn) begin
            g = grpSize();
            expV = OUT_W'((1 << g) - 1);
            expRdy = (DEPTH - q.size()) >= IN_W;
            chk("out_valid", 64'(outValid), 64'(expV));
            chk("count", 64'(count), 64'(q.size()));
            chk("in_ready", 64'(inReady), 64'(expRdy));
            chk("pause_req", 64'(pauseReq), 64'(!expRdy));
            for (int k = 0; k < g; k++) begin
                chk("out_data", outData[k*DATA_W +: DATA_W], q[k].d);
                chk("out_is_ctrl", 64'(outCtrl[k]), 64'(q[k].c));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setLane(int i, logic [63:0] d, logic c);
        inData[i*DATA_W +: DATA_W] = d;
        inCtrl[i] = c;
    endtask

    task automatic doReset();
        rst = 1'b1;
        inValid = '0;
        outReady = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        monOn = 1'b1;

        // dense push A,B then drain
        setLane(0, 64'hA, 1'b0);
        setLane(1, 64'hB, 1'b0);
        inValid = 2'b11;
        step();
        inValid = 2'b00;
        step();
        chk("ab_count", 64'(count), 64'd2);
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        chk("ab_drained", 64'(count), 64'd0);
        step();

        // sparse pushes C then D
        setLane(1, 64'hC, 1'b0);
        inValid = 2'b10;
        step();
        setLane(0, 64'hD, 1'b0);
        inValid = 2'b01;
        step();
        inValid = 2'b00;
        step();
        outReady = 1'b1;
        step();
        outReady = 1'b0;

        // X, BR, DS with continuous drain
        setLane(0, 64'h1111, 1'b0);
        setLane(1, 64'hB0B0, 1'b1);
        inValid = 2'b11;
        step();
        setLane(0, 64'hD5D5, 1'b0);
        inValid = 2'b01;
        step();
        inValid = 2'b00;
        outReady = 1'b1;
        repeat (3) step();
        outReady = 1'b0;

        // lone branch: held with HOLD_DS=1, issued alone with HOLD_DS=0
        doReset();
        setLane(0, 64'hBEEF, 1'b1);
        inValid = 2'b01;
        outReady = 1'b1;
        step();
        inValid = 2'b00;
        chk("nohold_valid", 64'(outValidB), 64'd1);
        chk("nohold_data", outDataB[DATA_W-1:0], 64'hBEEF);
        chk("hold_valid", 64'(outValid), 64'd0);
        repeat (2) step();
        setLane(0, 64'hD5, 1'b0);
        inValid = 2'b01;
        step();
        inValid = 2'b00;
        repeat (2) step();

        // fill to DEPTH-1, blocked push, then drain two
        doReset();
        repeat (7) begin
            setLane(0, 64'($urandom), 1'b0);
            setLane(1, 64'($urandom), 1'b0);
            inValid = 2'b11;
            step();
        end
        setLane(0, 64'h77, 1'b0);
        inValid = 2'b01;
        step();
        setLane(0, 64'h88, 1'b0);
        setLane(1, 64'h99, 1'b0);
        inValid = 2'b11;
        step();
        inValid = 2'b00;
        chk("full_count", 64'(count), 64'd15);
        chk("full_pause", 64'(pauseReq), 64'd1);
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        chk("refill_ready", 64'(inReady), 64'd1);
        step();

        // randomized traffic through the wrap point
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < IN_W; i++)
                setLane(i, {$urandom, $urandom},
                        $urandom_range(0, 3) == 0);
            inValid = IN_W'($urandom_range(0, 3));
            outReady = (n % 64 < 32) ? ($urandom_range(0, 3) == 0)
                                     : ($urandom_range(0, 3) != 0);
            flush = $urandom_range(0, 59) == 0;
            step();
        end
        flush = 1'b0;

        // flush with concurrent push and pop on a 5-entry queue
        doReset();
        for (int r = 0; r < 3; r++) begin
            setLane(0, 64'(100 + 2 * r), 1'b0);
            setLane(1, 64'(101 + 2 * r), 1'b0);
            inValid = (r == 2) ? 2'b01 : 2'b11;
            step();
        end
        chk("pre_flush", 64'(count), 64'd5);
        setLane(0, 64'hF0, 1'b0);
        setLane(1, 64'hF1, 1'b0);
        inValid = 2'b11;
        outReady = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        inValid = 2'b00;
        outReady = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(outValid), 64'd0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
